// File: rtl/water_valve_actuator.sv
// Valve motor sequencer: debounces the supply controller's command word and drives
// open/close travel against limit switches with a travel timeout and latched faults.
module water_valve_actuator #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TRAVEL_TIMEOUT = 1000,
  parameter int TIMER_WIDTH    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] valvule,
  input  logic       limit_open,
  input  logic       limit_closed,
  input  logic       fault_clear,
  output logic       motor_open,
  output logic       motor_close,
  output logic       valve_open,
  output logic       fault,
  output logic       invalid_code
);

  typedef enum logic [2:0] {
    S_INIT,
    S_CLOSED,
    S_OPENING,
    S_OPEN,
    S_CLOSING,
    S_FAULT
  } state_e;

  localparam logic [3:0]             CODE_OPEN    = 4'b1110;
  localparam logic [3:0]             CODE_CLOSE   = 4'b1111;
  localparam logic [TIMER_WIDTH-1:0] STABLE_N     = TIMER_WIDTH'(STABLE_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TRAVEL_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] ONE          = TIMER_WIDTH'(1);

  logic [3:0]             sample_q;
  logic [3:0]             cand_q, cand_d;
  logic [TIMER_WIDTH-1:0] deb_q, deb_d;
  logic                   accept;
  logic                   cmd_open_q, cmd_open_d;
  logic                   invalid_q, invalid_d;

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   both_limits;
  logic                   timed_out;

  logic motor_open_q, motor_close_q, valve_open_q, fault_q;

  // Debounce: a candidate word must be seen STABLE_CYCLES times in a row; it is
  // accepted once, on the edge where the run length first reaches the threshold.
  always_comb begin
    cand_d = cand_q;
    deb_d  = deb_q;
    if (sample_q != cand_q) begin
      cand_d = sample_q;
      deb_d  = ONE;
    end else if (deb_q < STABLE_N) begin
      deb_d = deb_q + ONE;
    end
    accept = (deb_d == STABLE_N) && ((deb_q != STABLE_N) || (sample_q != cand_q));
  end

  always_comb begin
    cmd_open_d = cmd_open_q;
    invalid_d  = invalid_q;
    if (fault_clear) begin
      invalid_d = 1'b0;
    end
    if (accept) begin
      cmd_open_d = (cand_d == CODE_OPEN);
      if ((cand_d != CODE_OPEN) && (cand_d != CODE_CLOSE)) begin
        invalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_q   <= CODE_CLOSE;
      cand_q     <= CODE_CLOSE;
      deb_q      <= '0;
      cmd_open_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      sample_q   <= valvule;
      cand_q     <= cand_d;
      deb_q      <= deb_d;
      cmd_open_q <= cmd_open_d;
      invalid_q  <= invalid_d;
    end
  end

  assign both_limits = limit_open & limit_closed;
  assign timed_out   = (timer_q >= TIMEOUT_LAST);

  // Travel sequencer. Every branch that leaves or enters a travel state leaves
  // timer_d at zero, so any reversal restarts the timeout window.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      S_INIT: begin
        state_d = limit_closed ? S_CLOSED : S_CLOSING;
      end
      S_CLOSED: begin
        if (!limit_closed) begin
          state_d = S_CLOSING;
        end else if (cmd_open_q) begin
          state_d = S_OPENING;
        end
      end
      S_OPENING: begin
        if (timed_out) begin
          state_d = S_FAULT;
        end else if (limit_open) begin
          state_d = S_OPEN;
        end else if (!cmd_open_q) begin
          state_d = S_CLOSING;
        end else begin
          timer_d = timer_q + ONE;
        end
      end
      S_OPEN: begin
        // A close request wins over a lost open limit: ambiguity resolves toward closed.
        if (!cmd_open_q) begin
          state_d = S_CLOSING;
        end else if (!limit_open) begin
          state_d = S_OPENING;
        end
      end
      S_CLOSING: begin
        if (timed_out) begin
          state_d = S_FAULT;
        end else if (limit_closed) begin
          state_d = S_CLOSED;
        end else if (cmd_open_q) begin
          state_d = S_OPENING;
        end else begin
          timer_d = timer_q + ONE;
        end
      end
      S_FAULT: begin
        if (fault_clear) begin
          state_d = S_CLOSING;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
    if (both_limits) begin
      state_d = S_FAULT;
      timer_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT;
      timer_q       <= '0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      valve_open_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      motor_open_q  <= (state_d == S_OPENING);
      motor_close_q <= (state_d == S_CLOSING);
      valve_open_q  <= (state_d == S_OPEN);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  assign motor_open   = motor_open_q;
  assign motor_close  = motor_close_q;
  assign valve_open   = valve_open_q;
  assign fault        = fault_q;
  assign invalid_code = invalid_q;

endmodule

// File: tb/tb_water_valve_actuator.sv
// Directed bench for water_valve_actuator: table-driven steady-state vectors plus
// hand-written sequences for latency, timeout, limit conflicts and async reset.
module tb_water_valve_actuator;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] valvule;
  logic       limit_open;
  logic       limit_closed;
  logic       fault_clear;
  logic       motor_open;
  logic       motor_close;
  logic       valve_open;
  logic       fault;
  logic       invalid_code;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected output bit order: {motor_open, motor_close, valve_open, fault, invalid_code}
  typedef struct {
    logic [3:0] valvule;
    logic       lim_open;
    logic       lim_closed;
    logic       clr;
    int         hold;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vec_a[8];
  vec_t vec_b[4];

  water_valve_actuator #(
    .STABLE_CYCLES (4),
    .TRAVEL_TIMEOUT(20),
    .TIMER_WIDTH   (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valvule     (valvule),
    .limit_open  (limit_open),
    .limit_closed(limit_closed),
    .fault_clear (fault_clear),
    .motor_open  (motor_open),
    .motor_close (motor_close),
    .valve_open  (valve_open),
    .fault       (fault),
    .invalid_code(invalid_code)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [3:0] v, input logic lo, input logic lc,
                              input logic c, input int h, input logic [4:0] e,
                              input string nm);
    vec_t r;
    r.valvule    = v;
    r.lim_open   = lo;
    r.lim_closed = lc;
    r.clr        = c;
    r.hold       = h;
    r.exp        = e;
    r.name       = nm;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [4:0] exp);
    logic [4:0] act;
    act = {motor_open, motor_close, valve_open, fault, invalid_code};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: outputs {mo,mc,vo,flt,inv} = %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    valvule      = v.valvule;
    limit_open   = v.lim_open;
    limit_closed = v.lim_closed;
    fault_clear  = v.clr;
    tick(v.hold);
    check(v.name, v.exp);
  endtask

  initial begin
    vec_a[0] = mk(4'b1111, 1'b0, 1'b1, 1'b0, 8, 5'b00000, "reset_to_closed");
    vec_a[1] = mk(4'b1110, 1'b0, 1'b1, 1'b0, 3, 5'b00000, "glitch_3cyc");
    vec_a[2] = mk(4'b1111, 1'b0, 1'b1, 1'b0, 8, 5'b00000, "glitch_rejected");
    vec_a[3] = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1, 5'b00010, "both_limits_closed");
    vec_a[4] = mk(4'b1111, 1'b1, 1'b1, 1'b1, 1, 5'b00010, "clear_blocked_both");
    vec_a[5] = mk(4'b1111, 1'b0, 1'b1, 1'b0, 3, 5'b00010, "fault_latched");
    vec_a[6] = mk(4'b1111, 1'b0, 1'b1, 1'b1, 1, 5'b01000, "clear_to_closing");
    vec_a[7] = mk(4'b1111, 1'b0, 1'b1, 1'b0, 1, 5'b00000, "closing_to_closed");

    vec_b[0] = mk(4'b1010, 1'b1, 1'b0, 1'b0, 5, 5'b00101, "invalid_accepted");
    vec_b[1] = mk(4'b1010, 1'b1, 1'b0, 1'b0, 1, 5'b01001, "invalid_closes");
    vec_b[2] = mk(4'b1111, 1'b0, 1'b0, 1'b1, 1, 5'b01000, "clear_invalid_only");
    vec_b[3] = mk(4'b1111, 1'b0, 1'b1, 1'b0, 1, 5'b00000, "closed_after_invalid");

    reset_n      = 1'b0;
    valvule      = 4'b1111;
    limit_open   = 1'b0;
    limit_closed = 1'b1;
    fault_clear  = 1'b0;
    tick(2);
    check("in_reset", 5'b00000);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) apply(vec_a[i]);

    // Open latency: STABLE_CYCLES+2 edges, then arrival at the open stop
    valvule = 4'b1110;
    tick(5);
    check("open_latency_minus1", 5'b00000);
    tick(1);
    check("open_latency", 5'b10000);
    limit_closed = 1'b0;
    tick(9);
    check("opening_travel", 5'b10000);
    limit_open = 1'b1;
    tick(1);
    check("open_reached", 5'b00100);

    for (int i = 0; i < 4; i++) apply(vec_b[i]);

    // Opening timeout at TRAVEL_TIMEOUT edges after motor_open rose
    valvule = 4'b1110;
    tick(6);
    check("t4_opening", 5'b10000);
    limit_closed = 1'b0;
    tick(19);
    check("open_timeout_minus1", 5'b10000);
    tick(1);
    check("open_timeout", 5'b00010);
    valvule = 4'b1111;
    tick(8);
    check("fault_ignores_cmd", 5'b00010);
    fault_clear = 1'b1;
    tick(1);
    check("fault_clear_closing", 5'b01000);
    fault_clear  = 1'b0;
    limit_closed = 1'b1;
    tick(1);
    check("t4_closed", 5'b00000);

    // Both limits while opening, then async reset mid-closing
    valvule = 4'b1110;
    tick(6);
    check("t6_opening", 5'b10000);
    limit_closed = 1'b0;
    tick(3);
    limit_open   = 1'b1;
    limit_closed = 1'b1;
    tick(1);
    check("both_limits_opening", 5'b00010);
    fault_clear = 1'b1;
    tick(1);
    check("clear_with_both", 5'b00010);
    fault_clear = 1'b0;
    valvule     = 4'b1111;
    tick(8);
    limit_open   = 1'b0;
    limit_closed = 1'b0;
    fault_clear  = 1'b1;
    tick(1);
    check("t6_clear_closing", 5'b01000);
    fault_clear = 1'b0;
    tick(3);
    check("t6_mid_closing", 5'b01000);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 5'b00000);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("init_to_closing", 5'b01000);
    tick(19);
    check("close_timeout_minus1", 5'b01000);
    tick(1);
    check("close_timeout", 5'b00010);
    fault_clear  = 1'b1;
    limit_closed = 1'b1;
    tick(1);
    check("final_clear", 5'b01000);
    fault_clear = 1'b0;
    tick(1);
    check("final_closed", 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
